// File: rtl/mult_issue_if.sv
// mult_issue_if: request, multiplier and writeback signal bundle for mult_issue_ctrl.
//
// Valid/ready semantics used on both the request and writeback channels:
// a transfer happens in the cycle where valid and ready are both high at the
// rising clock edge. A source holding valid keeps its payload stable until
// that transfer. Ready may depend combinationally on the other side's signals.
// The multiplier channel has no ready: start is a one-cycle pulse, and done is
// a one-cycle pulse with its result valid only while done is high.
//
// Signal groups (names keep the controller-side direction suffix):
//   req_*   execute stage -> controller request (valid/ready)
//   mult_*  controller <-> multiplier (start pulse, done pulse)
//   wb_*    controller -> writeback response (valid/ready)
// Modports: slave = the controller, master = its environment.
interface mult_issue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 5
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [2:0]            req_op_i;
    logic [DATA_WIDTH-1:0] req_a_i;
    logic [DATA_WIDTH-1:0] req_b_i;
    logic [RD_WIDTH-1:0]   req_rd_i;
    logic                  mult_start_o;
    logic [2:0]            mult_op_o;
    logic [DATA_WIDTH-1:0] mult_a_o;
    logic [DATA_WIDTH-1:0] mult_b_o;
    logic                  mult_done_i;
    logic [DATA_WIDTH-1:0] mult_result_i;
    logic                  wb_valid_o;
    logic                  wb_ready_i;
    logic [DATA_WIDTH-1:0] wb_result_o;
    logic [RD_WIDTH-1:0]   wb_rd_o;
    logic                  wb_err_o;

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, req_rd_i,
        input  mult_done_i, mult_result_i, wb_ready_i,
        output req_ready_o, mult_start_o, mult_op_o, mult_a_o, mult_b_o,
        output wb_valid_o, wb_result_o, wb_rd_o, wb_err_o
    );

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, req_rd_i,
        output mult_done_i, mult_result_i, wb_ready_i,
        input  req_ready_o, mult_start_o, mult_op_o, mult_a_o, mult_b_o,
        input  wb_valid_o, wb_result_o, wb_rd_o, wb_err_o
    );
endinterface

// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: issue/response sequencer sitting in front of the RV32M
// multiplier. Accepts one MUL/MULH/MULHSU/MULHU request at a time, pulses the
// multiplier start, waits for done (or a timeout), and presents the tagged
// result to writeback. Handles pipeline flush at every stage.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   flush_i      pipeline flush, kills the operation in flight
//   bus          mult_issue_if.slave (request, multiplier, writeback channels)
//   busy_o       controller is not idle
//   o_dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 RESP, 3 DRAIN)
module mult_issue_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2,
    parameter int TIMEOUT    = 8,
    parameter int RD_WIDTH   = 5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    mult_issue_if.slave bus,
    output logic        busy_o,
    output logic [1:0]  o_dbg_state
);
    localparam int LIMIT = LATENCY + TIMEOUT;
    localparam int CNT_W = $clog2(LIMIT + 1);
    // The counter value seen in the last BUSY/DRAIN cycle before it would
    // reach LIMIT; leaving on this cycle puts the timeout response at the same
    // distance from accept as a normal response is from done.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_result;
    logic [RD_WIDTH-1:0]   r_rd;
    logic                  r_err;
    logic                  r_wb_valid;

    logic w_ready;
    logic w_accept;
    logic w_legal;
    logic w_expire;

    // A new request may enter while idle, or in the same cycle the pending
    // response is taken by writeback (back-to-back without a bubble).
    assign w_ready  = !flush_i && (r_state == IDLE ||
                                   (r_state == RESP && bus.wb_ready_i));
    assign w_accept = bus.req_valid_i && w_ready;
    // funct3[2] set is a divide encoding: answered with an error, no start.
    assign w_legal  = !bus.req_op_i[2];
    assign w_expire = (r_cnt >= LAST_CNT);

    assign bus.req_ready_o  = w_ready;
    assign bus.mult_start_o = w_accept && w_legal;
    assign bus.mult_op_o    = bus.req_op_i;
    assign bus.mult_a_o     = bus.req_a_i;
    assign bus.mult_b_o     = bus.req_b_i;
    assign bus.wb_valid_o   = r_wb_valid;
    assign bus.wb_result_o  = r_result;
    assign bus.wb_rd_o      = r_rd;
    assign bus.wb_err_o     = r_err;
    assign busy_o           = (r_state != IDLE);
    assign o_dbg_state      = r_state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_result   <= '0;
            r_rd       <= '0;
            r_err      <= 1'b0;
            r_wb_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, RESP: begin
                    if (w_accept) begin
                        r_rd <= bus.req_rd_i;
                        if (w_legal) begin
                            r_state    <= BUSY;
                            r_cnt      <= '0;
                            r_wb_valid <= 1'b0;
                        end else begin
                            r_state    <= RESP;
                            r_err      <= 1'b1;
                            r_result   <= '0;
                            r_wb_valid <= 1'b1;
                        end
                    end else if (r_state == RESP && (flush_i || bus.wb_ready_i)) begin
                        // Response taken or dropped by flush.
                        r_state    <= IDLE;
                        r_wb_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (r_cnt != MAX_CNT) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (flush_i) begin
                        // The multiplier cannot abort; wait for it to finish
                        // unless it already finishes (or expires) right now.
                        r_state <= (bus.mult_done_i || w_expire) ? IDLE : DRAIN;
                    end else if (bus.mult_done_i) begin
                        r_state    <= RESP;
                        r_result   <= bus.mult_result_i;
                        r_err      <= 1'b0;
                        r_wb_valid <= 1'b1;
                    end else if (w_expire) begin
                        r_state    <= RESP;
                        r_result   <= '0;
                        r_err      <= 1'b1;
                        r_wb_valid <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_cnt != MAX_CNT) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (bus.mult_done_i || w_expire) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
